// File: rtl/nios2_oci_dct_monitor_pkg.sv
// +----------------------------------------------------------------------+
// | nios2_oci_tb_pkg : shared FSM state encoding and width helper        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package nios2_oci_tb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int f_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nios2_oci_dct_fifo.sv
// +----------------------------------------------------------------------+
// | nios2_oci_dct_fifo : registered slot FIFO, no fall-through           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module nios2_oci_dct_fifo
  import nios2_oci_tb_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int AW    = f_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // Full is judged on the registered level, so a same-cycle pop never frees room.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/nios2_oci_dct_monitor.sv
// +----------------------------------------------------------------------+
// | nios2_oci_dct_monitor : serialises DCT slot groups into a FIFO and   |
// | drains on test end. Optional NIOS2_OCI_DCT_CHECKSUM_EN adds an XOR   |
// | checksum output. Revision: 1.0                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module nios2_oci_dct_monitor
  import nios2_oci_tb_pkg::*;
#(
  parameter int SLOT_W   = 10,
  parameter int SLOTS    = 3,
  parameter int CNT_IN_W = 4,
  parameter int DEPTH    = 16,
  parameter int TOTAL_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        dct_valid,
  output logic                        dct_ready,
  input  logic [SLOTS*SLOT_W-1:0]     dct_buffer,
  input  logic [CNT_IN_W-1:0]         dct_count,
  input  logic                        test_ending,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLOT_W-1:0]           out_slot,
  output logic [f_clog2(DEPTH):0]     fifo_level,
  output logic [TOTAL_W-1:0]          slot_total,
  output logic                        count_err,
  output logic                        test_has_ended
`ifdef NIOS2_OCI_DCT_CHECKSUM_EN
  ,
  output logic [SLOT_W-1:0]           dct_checksum
`endif
);

  state_e                    state_q, state_d;
  logic [SLOTS*SLOT_W-1:0]   stage_q, stage_d;
  logic [CNT_IN_W-1:0]       rem_q, rem_d;
  logic [CNT_IN_W-1:0]       n_in;
  logic [TOTAL_W-1:0]        total_q;
  logic                      count_err_q;
  logic                      busy;
  logic                      accept;
  logic                      push;
  logic                      drained;
  logic                      fifo_full;
  logic                      fifo_empty;

  // Staging shifts right on every push, so the head slot is always bits [SLOT_W-1:0].
  assign busy     = (rem_q != '0);
  assign dct_ready = (state_q == ST_RUN) && !busy;
  assign accept   = dct_valid && dct_ready;
  assign push     = busy && !fifo_full;
  assign drained  = !busy && fifo_empty;
  assign n_in     = (dct_count > CNT_IN_W'(SLOTS)) ? CNT_IN_W'(SLOTS) : dct_count;
  assign out_valid = !fifo_empty;
  assign slot_total = total_q;
  assign count_err  = count_err_q;
  assign test_has_ended = (state_q == ST_DONE) || ((state_q == ST_DRAIN) && drained);

  always_comb begin
    stage_d = stage_q;
    rem_d   = rem_q;
    if (accept) begin
      stage_d = dct_buffer;
      rem_d   = n_in;
    end else if (push) begin
      stage_d = stage_q >> SLOT_W;
      rem_d   = rem_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (test_ending) state_d = ST_DRAIN;
      ST_DRAIN: if (drained)     state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      stage_q     <= '0;
      rem_q       <= '0;
      total_q     <= '0;
      count_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rem_q   <= rem_d;
      if (push) total_q <= total_q + 1'b1;
      if (accept && (dct_count > CNT_IN_W'(SLOTS))) count_err_q <= 1'b1;
    end
  end

`ifdef NIOS2_OCI_DCT_CHECKSUM_EN
  logic [SLOT_W-1:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (push && (state_q != ST_DONE)) begin
      csum_q <= csum_q ^ stage_q[SLOT_W-1:0];
    end
  end

  assign dct_checksum = csum_q;
`endif

  nios2_oci_dct_fifo #(
    .W     (SLOT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .din_i   (stage_q[SLOT_W-1:0]),
    .pop_i   (out_ready),
    .dout_o  (out_slot),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

`default_nettype wire
